axis_step_gen: RTL

Synthesizable AXI-Stream transmitter that produces the zero / step / zero stimulus sequence used to exercise stream filters such as the FIR. It is the driving end of an AXI-Stream link: it sources beats into a downstream receiver and optionally throttles TVALID with an internal LFSR, so back-pressure and bubble handling can be tested in hardware as well as in simulation. It sits upstream of the block under test; a separate sink or monitor drives TREADY.

---
 rtl/axis_step_gen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/axis_step_gen.sv
// AXI-Stream source emitting a zero / step / zero sequence, with optional
// LFSR gating of TVALID to exercise downstream bubble and back-pressure handling.
module axis_step_gen #(
  parameter int          DATA_WIDTH = 16,
  parameter int          LEN_WIDTH  = 16,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LEN_WIDTH-1:0]   pre_len,
  input  logic [LEN_WIDTH-1:0]   step_len,
  input  logic [LEN_WIDTH-1:0]   post_len,
  input  logic [DATA_WIDTH-1:0]  level,
  input  logic                   throttle_en,
  output logic                   busy,
  output logic                   done,
  output logic [LEN_WIDTH+1:0]   beats_sent,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast
);

  typedef enum logic [2:0] {IDLE, PRE, STEP, POST, DONE} state_t;

  state_t                state, state_n;
  logic [LEN_WIDTH-1:0]  cnt, cnt_n;
  logic [LEN_WIDTH-1:0]  step_q, post_q;
  logic [DATA_WIDTH-1:0] level_q;
  logic                  tvalid_q, tvalid_n;
  logic [15:0]           lfsr;
  logic                  hs, raise, cnt_last, later_nonzero;

  assign busy     = (state == PRE) || (state == STEP) || (state == POST);
  assign done     = (state == DONE);
  assign hs       = tvalid_q && m_axis_tready;
  assign raise    = !throttle_en || lfsr[0];
  assign cnt_last = (cnt == LEN_WIDTH'(1));

  // Data and last derive from state/counter only, which are frozen while stalled,
  // so the beat stays stable until it handshakes.
  always_comb begin
    later_nonzero = 1'b0;
    case (state)
      PRE:     later_nonzero = (step_q != '0) || (post_q != '0);
      STEP:    later_nonzero = (post_q != '0);
      default: later_nonzero = 1'b0;
    endcase
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = (state == STEP) ? level_q : '0;
  assign m_axis_tlast  = busy && cnt_last && !later_nonzero;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    tvalid_n = tvalid_q;
    case (state)
      IDLE: begin
        tvalid_n = 1'b0;
        if (start) begin
          if (pre_len != '0) begin
            state_n = PRE;  cnt_n = pre_len;  tvalid_n = raise;
          end else if (step_len != '0) begin
            state_n = STEP; cnt_n = step_len; tvalid_n = raise;
          end else if (post_len != '0) begin
            state_n = POST; cnt_n = post_len; tvalid_n = raise;
          end else begin
            state_n = DONE;
          end
        end
      end
      PRE, STEP, POST: begin
        if (!tvalid_q) begin
          tvalid_n = raise;
        end else if (m_axis_tready) begin
          if (cnt_last) begin
            tvalid_n = raise;
            if (state == PRE && step_q != '0) begin
              state_n = STEP; cnt_n = step_q;
            end else if (state != POST && post_q != '0) begin
              state_n = POST; cnt_n = post_q;
            end else begin
              state_n  = DONE;
              cnt_n    = '0;
              tvalid_n = 1'b0;
            end
          end else begin
            cnt_n    = cnt - 1'b1;
            tvalid_n = raise;
          end
        end
      end
      DONE: begin
        state_n  = IDLE;
        tvalid_n = 1'b0;
      end
      default: begin
        state_n  = IDLE;
        tvalid_n = 1'b0;
      end
    endcase
  end

  // The leading-zero length is consumed straight into the counter, so only the
  // later phase lengths need to be held.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      tvalid_q   <= 1'b0;
      step_q     <= '0;
      post_q     <= '0;
      level_q    <= '0;
      beats_sent <= '0;
      lfsr       <= LFSR_SEED;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      tvalid_q <= tvalid_n;
      if (state == IDLE && start) begin
        step_q     <= step_len;
        post_q     <= post_len;
        level_q    <= level;
        beats_sent <= '0;
      end else if (hs && beats_sent != {(LEN_WIDTH+2){1'b1}}) begin
        beats_sent <= beats_sent + 1'b1;
      end
      if (busy)
        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

endmodule
